// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer and Cause interrupt-pending logic.
// Produces the masked interrupt request and the priority vector for the exception stage.
module cp0_timer_intc #(
   parameter int N_EXT       = 6,
   parameter int COUNT_DIV   = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_EXT-1:0] i_ext_int,
   input  logic             i_wen,
   input  logic [4:0]       i_addr,
   input  logic [2:0]       i_sel,
   input  logic [31:0]      i_wdata,
   input  logic             i_status_ie,
   input  logic             i_status_exl,
   input  logic             i_status_erl,
   input  logic [7:0]       i_status_im,
   output logic [31:0]      o_count,
   output logic [31:0]      o_compare,
   output logic [7:0]       o_cause_ip,
   output logic             o_cause_ti,
   output logic             o_cause_dc,
   output logic             o_int_req,
   output logic [2:0]       o_int_vec
);

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
   localparam logic [4:0] ADDR_COUNT   = 5'd9;
   localparam logic [4:0] ADDR_COMPARE = 5'd11;
   localparam logic [4:0] ADDR_CAUSE   = 5'd13;

   logic [PW-1:0]    r_presc;
   logic [31:0]      r_count;
   logic [31:0]      r_compare;
   logic             r_ti;
   logic             r_dc;
   logic [1:0]       r_ip_sw;
   logic [N_EXT-1:0] r_sync [SYNC_STAGES];

   logic        w_wr;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_wr_cause;
   logic        w_tick;
   logic        w_run;
   logic [31:0] w_count_inc;
   logic        w_match;
   logic [5:0]  w_ext6;
   logic [7:0]  w_ip;
   logic [7:0]  w_pend;
   logic        w_int_req;
   logic [2:0]  w_vec;

   assign w_wr         = i_wen & (i_sel == 3'd0);
   assign w_wr_count   = w_wr & (i_addr == ADDR_COUNT);
   assign w_wr_compare = w_wr & (i_addr == ADDR_COMPARE);
   assign w_wr_cause   = w_wr & (i_addr == ADDR_CAUSE);

   assign w_tick      = (r_presc == PRESC_MAX);
   assign w_run       = w_tick & ~r_dc;
   assign w_count_inc = r_count + 32'd1;
   // Only a tick-driven increment can raise TI; a Count write landing on Compare cannot.
   assign w_match     = w_run & ~w_wr_count & (w_count_inc == r_compare);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc   <= '0;
         r_count   <= '0;
         r_compare <= '0;
         r_ti      <= 1'b0;
         r_dc      <= 1'b0;
         r_ip_sw   <= '0;
      end else begin
         if (w_wr_count)
            r_presc <= '0;
         else if (!r_dc)
            r_presc <= w_tick ? '0 : r_presc + PW'(1);

         if (w_wr_count)
            r_count <= i_wdata;
         else if (w_run)
            r_count <= w_count_inc;

         if (w_wr_compare)
            r_compare <= i_wdata;

         if (w_wr_compare)
            r_ti <= 1'b0;
         else if (w_match)
            r_ti <= 1'b1;

         if (w_wr_cause) begin
            r_ip_sw <= i_wdata[9:8];
            r_dc    <= i_wdata[27];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++)
            r_sync[s] <= '0;
      end else begin
         r_sync[0] <= i_ext_int;
         for (int s = 1; s < SYNC_STAGES; s++)
            r_sync[s] <= r_sync[s-1];
      end
   end

   // Unused external positions stay zero so IP bits without a line read 0.
   always_comb begin
      w_ext6            = '0;
      w_ext6[N_EXT-1:0] = r_sync[SYNC_STAGES-1];
   end

   assign w_ip      = {r_ti | w_ext6[5], w_ext6[4:0], r_ip_sw};
   assign w_pend    = w_ip & i_status_im;
   assign w_int_req = i_status_ie & ~i_status_exl & ~i_status_erl & (|w_pend);

   always_comb begin
      w_vec = '0;
      for (int k = 0; k < 8; k++)
         if (w_pend[k])
            w_vec = 3'(k);
   end

   assign o_count    = r_count;
   assign o_compare  = r_compare;
   assign o_cause_ip = w_ip;
   assign o_cause_ti = r_ti;
   assign o_cause_dc = r_dc;
   assign o_int_req  = w_int_req;
   assign o_int_vec  = w_int_req ? w_vec : 3'd0;

endmodule
